// File: rtl/handshake_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// handshake_arbiter_pkg
// Purpose : shared definitions for the send/ack handshake arbiter slice.
//           Holds the FSM state encoding, the default data width, the
//           grant index width and a helper that sizes the timeout counter.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package handshake_arbiter_pkg;

    // Arbiter FSM states. The numeric encoding is fixed so that waveform
    // viewers and any external decode see the same values everywhere.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_ACKD = 2'd2,
        ST_DROP = 2'd3
    } arbState_t;

    localparam int DATA_W_DEF = 4;

    // arb_grant is always two bits wide, enough for up to four requesters.
    localparam int GRANT_W = 2;

    // The timeout counter must be able to hold TIMEOUT_CYC. A disabled
    // timeout (0) still gets a one-bit counter so no zero-width vector exists.
    function automatic int timeoutCntWidth(input int timeoutCyc);
        return (timeoutCyc > 0) ? $clog2(timeoutCyc + 1) : 1;
    endfunction

endpackage

// File: rtl/handshake_arbiter_if.sv
// ---------------------------------------------------------------------------
// handshake_arbiter_if
// Purpose : bundles the requester-side and peripheral-side handshake signals
//           of the arbiter into one interface.
// Signals :
//   req_send    [N_REQ]         requester i has data on its slice
//   req_dados   [N_REQ*DATA_W]  requester i data at [i*DATA_W +: DATA_W]
//   req_ack     [N_REQ]         ack back to the granted requester
//   per_send                    send strobe towards the peripheral
//   per_dados   [DATA_W]        data towards the peripheral
//   per_ack                     ack from the peripheral
//   arb_grant   [2]             current / last granted requester index
//   arb_busy                    arbiter is not idle
//   arb_timeout                 one-cycle pulse when a transfer is aborted
// Modports: master = requesters + peripheral side, slave = the arbiter.
// ---------------------------------------------------------------------------
interface handshake_arbiter_if
    import handshake_arbiter_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = DATA_W_DEF
);

    logic [N_REQ-1:0]        req_send;
    logic [N_REQ*DATA_W-1:0] req_dados;
    logic [N_REQ-1:0]        req_ack;
    logic                    per_send;
    logic [DATA_W-1:0]       per_dados;
    logic                    per_ack;
    logic [GRANT_W-1:0]      arb_grant;
    logic                    arb_busy;
    logic                    arb_timeout;

    modport master (
        output req_send, req_dados, per_ack,
        input  req_ack, per_send, per_dados, arb_grant, arb_busy, arb_timeout
    );

    modport slave (
        input  req_send, req_dados, per_ack,
        output req_ack, per_send, per_dados, arb_grant, arb_busy, arb_timeout
    );

endinterface

// File: rtl/handshake_arbiter_rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Purpose : combinational round-robin picker. Finds the first asserted
//           request scanning upwards from i_lastGrant+1, wrapping mod N_REQ.
// Ports   :
//   i_req        [N_REQ]    request vector
//   i_lastGrant  [GRANT_W]  index granted most recently
//   o_anyReq                at least one request is asserted
//   o_grantIdx   [GRANT_W]  chosen index (0 when no request)
// ---------------------------------------------------------------------------
module rr_priority_picker
    import handshake_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]   i_req,
    input  logic [GRANT_W-1:0] i_lastGrant,
    output logic               o_anyReq,
    output logic [GRANT_W-1:0] o_grantIdx
);

    int               w_idx;
    logic [N_REQ-1:0] w_shifted;

    // Walk the candidates from farthest to nearest after the last grant, so
    // the final assignment that survives is the nearest asserted request.
    // Shifting instead of bit-selecting keeps the index width independent
    // of N_REQ.
    always_comb begin
        o_anyReq   = |i_req;
        o_grantIdx = '0;
        w_idx      = 0;
        w_shifted  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx     = (int'(i_lastGrant) + k) % N_REQ;
            w_shifted = i_req >> w_idx;
            if (w_shifted[0]) begin
                o_grantIdx = GRANT_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/handshake_arbiter.sv
// ---------------------------------------------------------------------------
// handshake_arbiter
// Purpose : shares one peripheral send/ack port between N_REQ requesters.
//           Grants one requester at a time in round-robin order, forwards its
//           latched data, returns the peripheral ack to that requester only,
//           and aborts transfers whose ack never arrives.
// Ports   :
//   arb_clock   single clock, all logic on posedge
//   arb_reset   synchronous, active-low reset
//   bus         handshake_arbiter_if.slave (see interface header)
// ---------------------------------------------------------------------------
module handshake_arbiter
    import handshake_arbiter_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input logic               arb_clock,
    input logic               arb_reset,
    handshake_arbiter_if.slave bus
);

    localparam int                 CNT_W     = timeoutCntWidth(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]   CNT_LAST  = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [GRANT_W-1:0] LAST_INIT = GRANT_W'(N_REQ - 1);

    arbState_t             r_state;
    arbState_t             w_nextState;
    logic [DATA_W-1:0]     r_data;
    logic [GRANT_W-1:0]    r_grant;
    logic [GRANT_W-1:0]    r_lastGrant;
    logic [CNT_W-1:0]      r_count;
    logic                  r_timeout;

    logic                  w_anyReq;
    logic [GRANT_W-1:0]    w_pickIdx;
    logic [N_REQ*DATA_W-1:0] w_dataShift;
    logic [DATA_W-1:0]     w_pickData;
    logic [N_REQ-1:0]      w_sendShift;
    logic                  w_released;
    logic                  w_timeoutHit;

    rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
        .i_req       (bus.req_send),
        .i_lastGrant (r_lastGrant),
        .o_anyReq    (w_anyReq),
        .o_grantIdx  (w_pickIdx)
    );

    assign w_dataShift  = bus.req_dados >> (int'(w_pickIdx) * DATA_W);
    assign w_pickData   = w_dataShift[DATA_W-1:0];
    assign w_sendShift  = bus.req_send >> r_grant;

    // The owner is only let go once both sides of the four-phase handshake
    // have returned low, otherwise a late ack could leak into the next grant.
    assign w_released   = !w_sendShift[0] && !bus.per_ack;
    assign w_timeoutHit = (TIMEOUT_CYC > 0) && (r_count == CNT_LAST);

    // State register. Reset wins over everything, including a transfer in
    // flight, so nothing is forwarded in the cycle after reset.
    always_ff @(posedge arb_clock) begin
        if (!arb_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. In SEND an arriving ack beats a simultaneous timeout.
    // ACKD and DROP share the same release condition.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_anyReq) w_nextState = ST_SEND;
            ST_SEND: begin
                if (bus.per_ack) begin
                    w_nextState = ST_ACKD;
                end else if (w_timeoutHit) begin
                    w_nextState = ST_DROP;
                end
            end
            ST_ACKD: if (w_released) w_nextState = ST_IDLE;
            ST_DROP: if (w_released) w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Datapath registers: data and grant are captured when leaving IDLE so
    // later changes on the requester bus cannot disturb the transfer. The
    // round-robin pointer moves only when the owner is released, which also
    // covers aborted transfers so a hung requester cannot hog the port.
    always_ff @(posedge arb_clock) begin
        if (!arb_reset) begin
            r_data      <= '0;
            r_grant     <= '0;
            r_lastGrant <= LAST_INIT;
            r_count     <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= (r_state == ST_SEND) && (w_nextState == ST_DROP);
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        r_data  <= w_pickData;
                        r_grant <= w_pickIdx;
                        r_count <= '0;
                    end
                end
                ST_SEND: begin
                    if (r_count != '1) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_ACKD, ST_DROP: begin
                    if (w_released) begin
                        r_lastGrant <= r_grant;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore output decode from registered state only.
    assign bus.per_send    = (r_state == ST_SEND);
    assign bus.per_dados   = (r_state == ST_IDLE) ? '0 : r_data;
    assign bus.req_ack     = (r_state == ST_ACKD) ? (N_REQ'(1) << r_grant) : '0;
    assign bus.arb_grant   = r_grant;
    assign bus.arb_busy    = (r_state != ST_IDLE);
    assign bus.arb_timeout = r_timeout;

endmodule

// File: tb/tb_handshake_arbiter.sv
// ---------------------------------------------------------------------------
// tb_handshake_arbiter
// Purpose : self-checking bench for handshake_arbiter. Directed scenarios plus
//           randomized transfers checked against a transaction-level model
//           of round-robin arbitration and the ack/timeout race.
// ---------------------------------------------------------------------------
module tb_handshake_arbiter;
    import handshake_arbiter_pkg::*;

    localparam int N_REQ       = 2;
    localparam int DATA_W      = 4;
    localparam int TIMEOUT_CYC = 16;

    logic arb_clock = 1'b0;
    logic arb_reset = 1'b0;
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   modelLast   = N_REQ - 1;

    handshake_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus();

    handshake_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .arb_clock (arb_clock),
        .arb_reset (arb_reset),
        .bus       (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 arb_clock = ~arb_clock;

    // Hard stop in case some wait below is never satisfied.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired testsFailed=%0d", testsFailed);
        $fatal(1, "[TB] watchdog");
    end

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge arb_clock);
        #1;
    endtask

    // Round-robin rule: first pending requester after the last grant, wrapping.
    function automatic int modelPick(input int last, input logic [N_REQ-1:0] pending);
        logic [N_REQ-1:0] s;
        for (int k = 1; k <= N_REQ; k++) begin
            s = pending >> ((last + k) % N_REQ);
            if (s[0]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    // Hold reset for two cycles with idle stimulus, then release.
    task automatic applyReset();
        arb_reset = 1'b0;
        bus.req_send = '0; bus.per_ack = 1'b0; bus.req_dados = '0;
        tick(); tick();
        arb_reset = 1'b1;
        modelLast = N_REQ - 1;
    endtask

    task automatic test_reset();
        arb_reset = 1'b0;
        bus.req_send = 2'b11; bus.per_ack = 1'b0; bus.req_dados = 8'hA5;
        tick(); tick();
        testsRun++; if (bus.per_send !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_per_send got=%0b exp=0", bus.per_send); end
        testsRun++; if (bus.per_dados !== 4'h0) begin testsFailed++; $display("[TB] FAIL rst_per_dados got=%0h exp=0", bus.per_dados); end
        testsRun++; if (bus.req_ack !== 2'b00) begin testsFailed++; $display("[TB] FAIL rst_req_ack got=%0b exp=00", bus.req_ack); end
        testsRun++; if (bus.arb_busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_busy got=%0b exp=0", bus.arb_busy); end
        testsRun++; if (bus.arb_timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_timeout got=%0b exp=0", bus.arb_timeout); end
        testsRun++; if (bus.arb_grant !== 2'd0) begin testsFailed++; $display("[TB] FAIL rst_grant got=%0d exp=0", bus.arb_grant); end
        arb_reset = 1'b1;
        bus.req_send = 2'b01; bus.req_dados = 8'h05;
        tick();
        testsRun++; if (bus.per_send !== 1'b1) begin testsFailed++; $display("[TB] FAIL first_per_send got=%0b exp=1", bus.per_send); end
        testsRun++; if (bus.per_dados !== 4'h5) begin testsFailed++; $display("[TB] FAIL first_per_dados got=%0h exp=5", bus.per_dados); end
        testsRun++; if (bus.arb_grant !== 2'd0) begin testsFailed++; $display("[TB] FAIL first_grant got=%0d exp=0", bus.arb_grant); end
        bus.per_ack = 1'b1;
        tick();
        testsRun++; if (bus.req_ack !== 2'b01) begin testsFailed++; $display("[TB] FAIL first_req_ack got=%0b exp=01", bus.req_ack); end
        bus.req_send = 2'b00; bus.per_ack = 1'b0;
        tick();
        testsRun++; if (bus.arb_busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL first_release_busy got=%0b exp=0", bus.arb_busy); end
        modelLast = 0;
    endtask

    task automatic test_contention();
        applyReset();
        bus.req_dados = {4'h9, 4'h3}; bus.req_send = 2'b11;
        tick();
        testsRun++; if (bus.arb_grant !== 2'd0) begin testsFailed++; $display("[TB] FAIL cont_grant0 got=%0d exp=0", bus.arb_grant); end
        testsRun++; if (bus.per_dados !== 4'h3) begin testsFailed++; $display("[TB] FAIL cont_data0 got=%0h exp=3", bus.per_dados); end
        bus.req_dados = {4'h9, 4'hC};
        tick();
        testsRun++; if (bus.per_dados !== 4'h3) begin testsFailed++; $display("[TB] FAIL cont_data_hold got=%0h exp=3", bus.per_dados); end
        testsRun++; if (bus.req_ack !== 2'b00) begin testsFailed++; $display("[TB] FAIL cont_early_ack got=%0b exp=00", bus.req_ack); end
        bus.per_ack = 1'b1;
        tick();
        testsRun++; if (bus.req_ack !== 2'b01) begin testsFailed++; $display("[TB] FAIL cont_ack0 got=%0b exp=01", bus.req_ack); end
        testsRun++; if (bus.per_send !== 1'b0) begin testsFailed++; $display("[TB] FAIL cont_send_off got=%0b exp=0", bus.per_send); end
        bus.req_send = 2'b10; bus.per_ack = 1'b0;
        tick();
        testsRun++; if (bus.req_ack !== 2'b00) begin testsFailed++; $display("[TB] FAIL cont_ack_clear got=%0b exp=00", bus.req_ack); end
        tick();
        testsRun++; if (bus.arb_grant !== 2'd1) begin testsFailed++; $display("[TB] FAIL cont_grant1 got=%0d exp=1", bus.arb_grant); end
        testsRun++; if (bus.per_dados !== 4'h9) begin testsFailed++; $display("[TB] FAIL cont_data1 got=%0h exp=9", bus.per_dados); end
        bus.per_ack = 1'b1;
        tick();
        testsRun++; if (bus.req_ack !== 2'b10) begin testsFailed++; $display("[TB] FAIL cont_ack1 got=%0b exp=10", bus.req_ack); end
        bus.req_send = 2'b00; bus.per_ack = 1'b0;
        tick();
        modelLast = 1;
    endtask

    task automatic test_fairness();
        logic [N_REQ-1:0] expAck;
        applyReset();
        for (int t = 0; t < 4; t++) begin
            bus.req_send = 2'b11; bus.req_dados = 8'h00;
            tick();
            testsRun++; if (bus.arb_grant !== 2'(t % 2)) begin testsFailed++; $display("[TB] FAIL fair_grant[%0d] got=%0d exp=%0d", t, bus.arb_grant, t % 2); end
            bus.per_ack = 1'b1;
            tick();
            expAck = N_REQ'(1) << (t % 2);
            testsRun++; if (bus.req_ack !== expAck) begin testsFailed++; $display("[TB] FAIL fair_ack[%0d] got=%0b exp=%0b", t, bus.req_ack, expAck); end
            bus.req_send = 2'b11 & ~expAck; bus.per_ack = 1'b0;
            tick();
        end
        bus.req_send = 2'b00;
        modelLast = 1;
    endtask

    task automatic test_timeout();
        int sendCycles;
        bus.req_send = 2'b11; bus.per_ack = 1'b0;
        tick();
        testsRun++; if (bus.arb_grant !== 2'd0) begin testsFailed++; $display("[TB] FAIL to_grant got=%0d exp=0", bus.arb_grant); end
        sendCycles = 0;
        while (bus.per_send === 1'b1 && sendCycles < 40) begin
            tick();
            sendCycles++;
        end
        testsRun++; if (sendCycles != TIMEOUT_CYC) begin testsFailed++; $display("[TB] FAIL to_cycles got=%0d exp=%0d", sendCycles, TIMEOUT_CYC); end
        testsRun++; if (bus.arb_timeout !== 1'b1) begin testsFailed++; $display("[TB] FAIL to_pulse got=%0b exp=1", bus.arb_timeout); end
        testsRun++; if (bus.req_ack !== 2'b00) begin testsFailed++; $display("[TB] FAIL to_req_ack got=%0b exp=00", bus.req_ack); end
        tick();
        testsRun++; if (bus.arb_timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL to_pulse_width got=%0b exp=0", bus.arb_timeout); end
        testsRun++; if (bus.arb_busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL to_drop_hold got=%0b exp=1", bus.arb_busy); end
        bus.req_send = 2'b10;
        tick();
        tick();
        testsRun++; if (bus.arb_grant !== 2'd1) begin testsFailed++; $display("[TB] FAIL to_rotate got=%0d exp=1", bus.arb_grant); end
        bus.per_ack = 1'b1;
        tick();
        bus.req_send = 2'b00; bus.per_ack = 1'b0;
        tick();
        modelLast = 1;
    endtask

    task automatic test_ack_last_cycle();
        bus.req_send = 2'b01; bus.per_ack = 1'b0;
        tick();
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
            tick();
            testsRun++; if (bus.arb_timeout !== 1'b0 || bus.per_send !== 1'b1) begin testsFailed++; $display("[TB] FAIL last_wait[%0d] timeout=%0b send=%0b exp=0/1", i, bus.arb_timeout, bus.per_send); end
        end
        bus.per_ack = 1'b1;
        tick();
        testsRun++; if (bus.req_ack !== 2'b01) begin testsFailed++; $display("[TB] FAIL last_ack got=%0b exp=01", bus.req_ack); end
        testsRun++; if (bus.arb_timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL last_no_pulse got=%0b exp=0", bus.arb_timeout); end
        tick();
        testsRun++; if (bus.arb_timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL last_no_late_pulse got=%0b exp=0", bus.arb_timeout); end
        bus.req_send = 2'b00; bus.per_ack = 1'b0;
        tick();
        modelLast = 0;
    endtask

    task automatic test_reset_mid();
        bus.req_send = 2'b10; bus.per_ack = 1'b0;
        tick();
        bus.per_ack = 1'b1;
        tick();
        testsRun++; if (bus.req_ack !== 2'b10) begin testsFailed++; $display("[TB] FAIL mid_pre_ack got=%0b exp=10", bus.req_ack); end
        arb_reset = 1'b0;
        tick();
        testsRun++; if (bus.req_ack !== 2'b00) begin testsFailed++; $display("[TB] FAIL mid_req_ack got=%0b exp=00", bus.req_ack); end
        testsRun++; if (bus.arb_busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_busy got=%0b exp=0", bus.arb_busy); end
        testsRun++; if (bus.arb_grant !== 2'd0) begin testsFailed++; $display("[TB] FAIL mid_grant got=%0d exp=0", bus.arb_grant); end
        arb_reset = 1'b1;
        bus.req_send = 2'b11; bus.per_ack = 1'b0;
        tick();
        testsRun++; if (bus.arb_grant !== 2'd0) begin testsFailed++; $display("[TB] FAIL mid_next_grant got=%0d exp=0", bus.arb_grant); end
        bus.per_ack = 1'b1;
        tick();
        bus.req_send = 2'b00; bus.per_ack = 1'b0;
        tick();
        modelLast = 0;
    endtask

    task automatic test_random();
        logic [N_REQ-1:0]        pending, expAck;
        logic [N_REQ*DATA_W-1:0] dados, tmp;
        logic [DATA_W-1:0]       expData;
        int ackDelay, expG, sendCycles, expCycles;
        bit dropEarly, expTimeout;
        for (int r = 0; r < 30; r++) begin
            pending    = N_REQ'($urandom_range(1, 3));
            dados      = (N_REQ*DATA_W)'($urandom);
            ackDelay   = $urandom_range(0, 20);
            dropEarly  = 1'($urandom_range(0, 1));
            expG       = modelPick(modelLast, pending);
            tmp        = dados >> (expG * DATA_W);
            expData    = tmp[DATA_W-1:0];
            expTimeout = (ackDelay >= TIMEOUT_CYC);
            expCycles  = expTimeout ? TIMEOUT_CYC : ackDelay + 1;
            expAck     = expTimeout ? '0 : (N_REQ'(1) << expG);
            bus.req_send = pending; bus.req_dados = dados; bus.per_ack = 1'b0;
            tick();
            testsRun++; if (bus.arb_grant !== 2'(expG)) begin testsFailed++; $display("[TB] FAIL rnd_grant[%0d] got=%0d exp=%0d", r, bus.arb_grant, expG); end
            sendCycles = 0;
            while (bus.per_send === 1'b1 && sendCycles < 40) begin
                testsRun++; if (bus.per_dados !== expData) begin testsFailed++; $display("[TB] FAIL rnd_data[%0d] got=%0h exp=%0h", r, bus.per_dados, expData); end
                bus.req_dados = (N_REQ*DATA_W)'($urandom);
                if (dropEarly && sendCycles == 1) bus.req_send = pending & ~(N_REQ'(1) << expG);
                bus.per_ack = (sendCycles >= ackDelay);
                tick();
                sendCycles++;
            end
            testsRun++; if (sendCycles != expCycles) begin testsFailed++; $display("[TB] FAIL rnd_cycles[%0d] got=%0d exp=%0d", r, sendCycles, expCycles); end
            testsRun++; if (bus.arb_timeout !== expTimeout) begin testsFailed++; $display("[TB] FAIL rnd_timeout[%0d] got=%0b exp=%0b", r, bus.arb_timeout, expTimeout); end
            testsRun++; if (bus.req_ack !== expAck) begin testsFailed++; $display("[TB] FAIL rnd_ack[%0d] got=%0b exp=%0b", r, bus.req_ack, expAck); end
            bus.req_send = '0; bus.per_ack = 1'b1;
            tick();
            testsRun++; if (bus.arb_busy !== 1'b1 || bus.req_ack !== expAck) begin testsFailed++; $display("[TB] FAIL rnd_hold[%0d] busy=%0b ack=%0b exp=1/%0b", r, bus.arb_busy, bus.req_ack, expAck); end
            bus.per_ack = 1'b0;
            tick();
            testsRun++; if (bus.arb_busy !== 1'b0 || bus.req_ack !== 2'b00) begin testsFailed++; $display("[TB] FAIL rnd_release[%0d] busy=%0b ack=%0b exp=0/00", r, bus.arb_busy, bus.req_ack); end
            modelLast = expG;
        end
    endtask

    // Scenario sequence; each task leaves the arbiter idle for the next one.
    initial begin
        bus.req_send = '0; bus.req_dados = '0; bus.per_ack = 1'b0;
        test_reset();
        test_contention();
        test_fairness();
        test_timeout();
        test_ack_last_cycle();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
